// File: rtl/lutram_bist.sv
// Built-in self test for a small distributed RAM. Each run clears the RAM,
// writes a selectable pattern and reads it back, counting mismatches.
module lutram_bist #(
  parameter int          A_WIDTH         = 6,
  parameter int          D_WIDTH         = 1,
  parameter logic [31:0] DIV_COUNTER_END = 32'h00FF_FFFF
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [1:0]         mode_i,
  input  logic               inject_i,
  output logic [D_WIDTH-1:0] q_o,
  output logic [A_WIDTH-1:0] addr_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               pass_o,
  output logic [A_WIDTH:0]   err_cnt_o
);

  localparam logic [2:0] S_INITIAL = 3'd0;
  localparam logic [2:0] S_CLEAR   = 3'd1;
  localparam logic [2:0] S_WRITE   = 3'd2;
  localparam logic [2:0] S_READ    = 3'd3;
  localparam logic [2:0] S_FINISH  = 3'd4;

  localparam int DEPTH = 2 ** A_WIDTH;
  localparam logic [A_WIDTH:0] ERR_MAX = {1'b1, {A_WIDTH{1'b0}}};

  logic [D_WIDTH-1:0] mem [DEPTH];

  logic [31:0]        div_cnt;
  logic               step;
  logic [2:0]         state;
  logic [A_WIDTH-1:0] addr;
  logic [1:0]         mode_q;
  logic [A_WIDTH:0]   err_cnt;
  logic               we;
  logic [D_WIDTH-1:0] wdata;
  logic [D_WIDTH-1:0] pattern;
  logic               last_addr;
  logic               mismatch;

  assign step = (div_cnt == DIV_COUNTER_END);

  always_ff @(posedge clk_i) begin
    if (rst_i || step) div_cnt <= '0;
    else               div_cnt <= div_cnt + 32'd1;
  end

  always_comb begin
    pattern = '0;
    case (mode_q)
      2'd0:    pattern = {D_WIDTH{addr[0]}};
      2'd1:    pattern = '1;
      2'd2:    pattern = D_WIDTH'(addr);
      default: pattern = ~{D_WIDTH{addr[0]}};
    endcase
  end

  // Fault injection only flips bit 0 so a single-bit RAM still sees it.
  always_comb begin
    we    = 1'b0;
    wdata = '0;
    if (state == S_CLEAR) begin
      we = 1'b1;
    end else if (state == S_WRITE) begin
      we       = 1'b1;
      wdata    = pattern;
      wdata[0] = pattern[0] ^ inject_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (we && step && !rst_i) mem[addr] <= wdata;
  end

  assign q_o       = mem[addr];
  assign last_addr = &addr;
  assign mismatch  = (q_o != pattern);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= S_INITIAL;
      addr    <= '0;
      err_cnt <= '0;
      mode_q  <= 2'd0;
    end else if (step) begin
      case (state)
        S_INITIAL: begin
          state   <= S_CLEAR;
          addr    <= '0;
          mode_q  <= mode_i;
          err_cnt <= '0;
        end
        S_CLEAR: begin
          addr <= addr + 1'b1;
          if (last_addr) state <= S_WRITE;
        end
        S_WRITE: begin
          addr <= addr + 1'b1;
          if (last_addr) state <= S_READ;
        end
        S_READ: begin
          addr <= addr + 1'b1;
          if (mismatch && err_cnt != ERR_MAX) err_cnt <= err_cnt + 1'b1;
          if (last_addr) state <= S_FINISH;
        end
        S_FINISH: begin
          addr <= '0;
          if (start_i) begin
            state   <= S_CLEAR;
            mode_q  <= mode_i;
            err_cnt <= '0;
          end
        end
        default: begin
          state <= S_INITIAL;
          addr  <= '0;
        end
      endcase
    end
  end

  assign addr_o    = addr;
  assign err_cnt_o = err_cnt;
  assign busy_o    = (state == S_CLEAR) || (state == S_WRITE) || (state == S_READ);
  assign done_o    = (state == S_FINISH);
  assign pass_o    = done_o && (err_cnt == '0);

endmodule
